// File: rtl/cmo_dc_arbiter.sv
// Purpose : shares the single L1D$ CMO port between NUM_REQ requesters (index 0 = cmo_fu);
//           round-robin grant with lock-until-accept, bounded outstanding count and
//           in-order routing of L1D$ acks back to the originating requester.
// Latency : 0-cycle combinational request path; acks are routed in the same cycle they arrive.
// Backpressure: a presented-but-unaccepted request locks the grant until the L1D$ takes it;
//           no request is presented while MAX_OUTSTANDING CMOs are awaiting their ack.
// Ports   : clk_i/rst_i (async active-high reset), cmo_req_i/cmo_resp_o (per requester),
//           cmo_dc_req_o/cmo_dc_resp_i (L1D$ side), busy_o, err_o (sticky spurious-ack flag).
// Config  : define CMO_ARB_FENCE_EN to treat CLEAN_ALL/FLUSH_ALL/INVAL_ALL as fences.

package cmo_dc_arbiter_pkg;
   localparam logic [3:0] CMO_CLEAN     = 4'd0;
   localparam logic [3:0] CMO_FLUSH     = 4'd1;
   localparam logic [3:0] CMO_INVAL     = 4'd2;
   localparam logic [3:0] CMO_CLEAN_ALL = 4'd3;
   localparam logic [3:0] CMO_FLUSH_ALL = 4'd4;
   localparam logic [3:0] CMO_INVAL_ALL = 4'd5;

   typedef struct packed {
      logic        req;
      logic [7:0]  trans_id;
      logic [63:0] address;
      logic [3:0]  cmo_op;
   } cmo_req_t;

   typedef struct packed {
      logic       req_ready;
      logic       ack;
      logic [7:0] trans_id;
   } cmo_resp_t;
endpackage

module cmo_dc_arbiter
   import cmo_dc_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ         = 2,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  cmo_req_t  cmo_req_i  [NUM_REQ],
   output cmo_resp_t cmo_resp_o [NUM_REQ],
   output cmo_req_t  cmo_dc_req_o,
   input  cmo_resp_t cmo_dc_resp_i,
   output logic      busy_o,
   output logic      err_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
   logic             lock_q, lock_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];

   logic [IDX_W-1:0] sel, cand, head;
   logic             sel_vld, can_issue, accept, pop, any_req;
   int unsigned      idx;

`ifdef CMO_ARB_FENCE_EN
   logic fence_q, fence_d, is_fence;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Arbitration: a held lock wins; otherwise scan from rr_ptr with wrap-around.
   always_comb begin
      sel     = lock_idx_q;
      sel_vld = 1'b0;
      idx     = 0;
      cand    = '0;
      any_req = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         any_req = any_req | cmo_req_i[i].req;
      end
      if (lock_q) begin
         sel_vld = cmo_req_i[lock_idx_q].req;
      end else begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IDX_W'(idx);
            if (!sel_vld && cmo_req_i[cand].req) begin
               sel_vld = 1'b1;
               sel     = cand;
            end
         end
      end
   end

   // Issue gate uses the registered count only, so an ack in the same cycle
   // never frees a slot early. Outputs stay quiet while reset is asserted.
`ifdef CMO_ARB_FENCE_EN
   always_comb begin
      is_fence  = (cmo_req_i[sel].cmo_op == CMO_CLEAN_ALL) ||
                  (cmo_req_i[sel].cmo_op == CMO_FLUSH_ALL) ||
                  (cmo_req_i[sel].cmo_op == CMO_INVAL_ALL);
      can_issue = !rst_i && (count_q < CNT_W'(MAX_OUTSTANDING)) && !fence_q &&
                  (!is_fence || (count_q == '0));
   end
`else
   always_comb begin
      can_issue = !rst_i && (count_q < CNT_W'(MAX_OUTSTANDING));
   end
`endif

   // Output logic.
   always_comb begin
      cmo_dc_req_o = '0;
      if (sel_vld) begin
         cmo_dc_req_o     = cmo_req_i[sel];
         cmo_dc_req_o.req = can_issue;
      end
      accept = cmo_dc_req_o.req & cmo_dc_resp_i.req_ready;
      pop    = cmo_dc_resp_i.ack && (count_q != '0);
      head   = fifo_q[rd_ptr_q];
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cmo_resp_o[i] = '0;
         if (accept && (sel == IDX_W'(i))) cmo_resp_o[i].req_ready = 1'b1;
         if (pop && (head == IDX_W'(i))) begin
            cmo_resp_o[i].ack      = 1'b1;
            cmo_resp_o[i].trans_id = cmo_dc_resp_i.trans_id;
         end
      end
      busy_o = !rst_i && ((count_q != '0) || any_req);
      err_o  = err_q;
   end

   // Next-state logic.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (accept) begin
         rr_ptr_d = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
         lock_d   = 1'b0;
      end else if (sel_vld) begin
         // Holds the grant whether stalled by req_ready or by the issue gate,
         // so a blocked requester cannot be starved by later arrivals.
         lock_d     = 1'b1;
         lock_idx_d = sel;
      end else begin
         lock_d = 1'b0;
      end
      count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);
      wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      err_d    = err_q | (cmo_dc_resp_i.ack && (count_q == '0));
`ifdef CMO_ARB_FENCE_EN
      // A fence is only issued with nothing outstanding and blocks further issue,
      // so the next ack popped is always the fence's own.
      fence_d = fence_q & ~pop;
      if (accept && is_fence) fence_d = 1'b1;
`endif
   end

   // State registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
`ifdef CMO_ARB_FENCE_EN
         fence_q    <= 1'b0;
`endif
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
`ifdef CMO_ARB_FENCE_EN
         fence_q    <= fence_d;
`endif
      end
   end

   // Id FIFO storage; validity is tracked by count/pointers alone.
   always_ff @(posedge clk_i) begin
      if (accept) fifo_q[wr_ptr_q] <= sel;
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(accept && !pop && (count_q == CNT_W'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_cmo_dc_arbiter.sv
module tb_cmo_dc_arbiter;
   import cmo_dc_arbiter_pkg::*;

   logic      clk, rst;
   cmo_req_t  req_a  [2];
   cmo_resp_t resp_a [2];
   cmo_req_t  dc_req;
   cmo_resp_t dc_resp;
   logic      busy, err;

   int checks   = 0;
   int failures = 0;

   cmo_dc_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(4)) dut (
      .clk_i(clk), .rst_i(rst), .cmo_req_i(req_a), .cmo_resp_o(resp_a),
      .cmo_dc_req_o(dc_req), .cmo_dc_resp_i(dc_resp), .busy_o(busy), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r0, r1, rdy, ack;
      logic [7:0] atid;
      logic       dcreq;
      logic [7:0] dctid;
      logic       rdy0, rdy1, ack0, ack1;
      logic [7:0] tid0, tid1;
      logic       busy, err;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [3:0] op);
      req_a[i].req      = v;
      req_a[i].trans_id = (i == 1) ? 8'h21 : 8'h10;
      req_a[i].address  = 64'h1000 * (i + 1);
      req_a[i].cmo_op   = op;
   endtask

   task automatic addv(input logic r0, r1, rdy, ack, input logic [7:0] atid,
                       input logic dcreq, input logic [7:0] dctid,
                       input logic rdy0, rdy1, ack0, ack1,
                       input logic [7:0] tid0, tid1, input logic bsy, er);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.ack = ack; v.atid = atid;
      v.dcreq = dcreq; v.dctid = dctid; v.rdy0 = rdy0; v.rdy1 = rdy1;
      v.ack0 = ack0; v.ack1 = ack1; v.tid0 = tid0; v.tid1 = tid1;
      v.busy = bsy; v.err = er;
      vq.push_back(v);
   endtask

   task automatic drive(input logic rdy, input logic ack, input logic [7:0] atid);
      dc_resp.req_ready = rdy;
      dc_resp.ack       = ack;
      dc_resp.trans_id  = atid;
   endtask

   initial begin
      //      r0 r1 rdy ack atid  | dcreq dctid rdy0 rdy1 ack0 ack1 tid0  tid1  busy err
      // round robin with acks
      addv(1, 1, 1, 0, 8'h00,  1, 8'h10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 1, 1, 0, 8'h00,  1, 8'h21, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 1, 1, 1, 8'hA0,  1, 8'h10, 1, 0, 1, 0, 8'hA0, 8'h00, 1, 0);
      addv(1, 1, 1, 1, 8'hA1,  1, 8'h21, 0, 1, 0, 1, 8'h00, 8'hA1, 1, 0);
      addv(0, 0, 1, 1, 8'hA2,  0, 8'h00, 0, 0, 1, 0, 8'hA2, 8'h00, 1, 0);
      addv(0, 0, 1, 1, 8'hA3,  0, 8'h00, 0, 0, 0, 1, 8'h00, 8'hA3, 1, 0);
      addv(0, 0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      // lock-until-accept
      addv(0, 1, 0, 0, 8'h00,  1, 8'h21, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 1, 0, 0, 8'h00,  1, 8'h21, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 1, 0, 0, 8'h00,  1, 8'h21, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 1, 1, 0, 8'h00,  1, 8'h21, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 0, 1, 0, 8'h00,  1, 8'h10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(0, 0, 0, 1, 8'hB0,  0, 8'h00, 0, 0, 0, 1, 8'h00, 8'hB0, 1, 0);
      addv(0, 0, 0, 1, 8'hB1,  0, 8'h00, 0, 0, 1, 0, 8'hB1, 8'h00, 1, 0);
      addv(0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      // fill to MAX_OUTSTANDING, ack and pending in the same cycle
      addv(1, 0, 1, 0, 8'h00,  1, 8'h10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 0, 1, 0, 8'h00,  1, 8'h10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 0, 1, 0, 8'h00,  1, 8'h10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 0, 1, 0, 8'h00,  1, 8'h10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 0, 1, 0, 8'h00,  0, 8'h10, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(1, 0, 1, 1, 8'hC0,  0, 8'h10, 0, 0, 1, 0, 8'hC0, 8'h00, 1, 0);
      addv(1, 0, 1, 0, 8'h00,  1, 8'h10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
      addv(0, 0, 1, 1, 8'hC1,  0, 8'h00, 0, 0, 1, 0, 8'hC1, 8'h00, 1, 0);
      addv(0, 0, 1, 1, 8'hC2,  0, 8'h00, 0, 0, 1, 0, 8'hC2, 8'h00, 1, 0);
      addv(0, 0, 1, 1, 8'hC3,  0, 8'h00, 0, 0, 1, 0, 8'hC3, 8'h00, 1, 0);
      addv(0, 0, 1, 1, 8'hC4,  0, 8'h00, 0, 0, 1, 0, 8'hC4, 8'h00, 1, 0);
      // spurious ack sets the sticky error
      addv(0, 0, 1, 1, 8'hD0,  0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      addv(0, 0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
      addv(0, 1, 1, 0, 8'h00,  1, 8'h21, 0, 1, 0, 0, 8'h00, 8'h00, 1, 1);
      addv(0, 0, 1, 1, 8'hD1,  0, 8'h00, 0, 0, 0, 1, 8'h00, 8'hD1, 1, 1);

      // reset behaviour with a request already presented
      rst = 1'b1;
      set_req(0, 1'b1, CMO_CLEAN);
      set_req(1, 1'b0, CMO_CLEAN);
      drive(1'b0, 1'b0, 8'h00);
      #12;
      chk("rst_dcreq", dc_req.req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_rdy0", resp_a[0].req_ready, 0);
      rst = 1'b0;
      #1;
      chk("rst_rel_dcreq", dc_req.req, 1);
      chk("rst_rel_dctid", dc_req.trans_id, 8'h10);
      set_req(0, 1'b0, CMO_CLEAN);
      rst = 1'b1;
      #8;
      rst = 1'b0;

      for (int r = 0; r < vq.size(); r++) begin
         @(posedge clk); #1;
         set_req(0, vq[r].r0, CMO_CLEAN);
         set_req(1, vq[r].r1, CMO_CLEAN);
         drive(vq[r].rdy, vq[r].ack, vq[r].atid);
         @(negedge clk);
         chk($sformatf("row%0d_dcreq", r), dc_req.req, vq[r].dcreq);
         chk($sformatf("row%0d_dctid", r), dc_req.trans_id, vq[r].dctid);
         chk($sformatf("row%0d_rdy0", r), resp_a[0].req_ready, vq[r].rdy0);
         chk($sformatf("row%0d_rdy1", r), resp_a[1].req_ready, vq[r].rdy1);
         chk($sformatf("row%0d_ack0", r), resp_a[0].ack, vq[r].ack0);
         chk($sformatf("row%0d_ack1", r), resp_a[1].ack, vq[r].ack1);
         chk($sformatf("row%0d_tid0", r), resp_a[0].trans_id, vq[r].tid0);
         chk($sformatf("row%0d_tid1", r), resp_a[1].trans_id, vq[r].tid1);
         chk($sformatf("row%0d_busy", r), busy, vq[r].busy);
         chk($sformatf("row%0d_err", r), err, vq[r].err);
      end

      // sticky error clears only on reset
      @(posedge clk); #1;
      set_req(0, 1'b0, CMO_CLEAN);
      set_req(1, 1'b0, CMO_CLEAN);
      drive(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("err_sticky", err, 1);
      rst = 1'b1;
      #1;
      chk("err_clr", err, 0);
      rst = 1'b0;

      // reset mid-operation: ack for a pre-reset CMO is treated as spurious
      @(posedge clk); #1;
      set_req(1, 1'b1, CMO_CLEAN);
      drive(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      chk("mid_dcreq", dc_req.req, 1);
      @(posedge clk); #1;
      set_req(1, 1'b0, CMO_CLEAN);
      drive(1'b0, 1'b0, 8'h00);
      chk("mid_busy_pre", busy, 1);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      chk("mid_busy_post", busy, 0);
      drive(1'b0, 1'b1, 8'hE0);
      #1;
      chk("mid_ack1", resp_a[1].ack, 0);
      chk("mid_tid1", resp_a[1].trans_id, 8'h00);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00);
      chk("mid_err", err, 1);
      rst = 1'b1;
      #2;
      rst = 1'b0;

      // *_ALL op behind two outstanding CLEANs
      @(posedge clk); #1;
      set_req(1, 1'b1, CMO_CLEAN);
      drive(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      chk("all_c1", dc_req.trans_id, 8'h21);
      @(posedge clk); #1;
      @(negedge clk);
      chk("all_c2", resp_a[1].req_ready, 1);
      @(posedge clk); #1;
      set_req(1, 1'b0, CMO_CLEAN);
      set_req(0, 1'b1, CMO_FLUSH_ALL);
      @(negedge clk);
`ifdef CMO_ARB_FENCE_EN
      chk("fence_hold_dcreq", dc_req.req, 0);
      chk("fence_hold_dctid", dc_req.trans_id, 8'h10);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 8'hF0);
      @(negedge clk);
      chk("fence_ack1a", resp_a[1].ack, 1);
      chk("fence_hold2", dc_req.req, 0);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 8'hF1);
      @(negedge clk);
      chk("fence_ack1b", resp_a[1].trans_id, 8'hF1);
      chk("fence_hold3", dc_req.req, 0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      chk("fence_issue", resp_a[0].req_ready, 1);
      @(posedge clk); #1;
      set_req(0, 1'b0, CMO_CLEAN);
      set_req(1, 1'b1, CMO_CLEAN);
      @(negedge clk);
      chk("fence_block_dcreq", dc_req.req, 0);
      chk("fence_block_dctid", dc_req.trans_id, 8'h21);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 8'hF2);
      @(negedge clk);
      chk("fence_ack0", resp_a[0].ack, 1);
      chk("fence_block2", dc_req.req, 0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      chk("fence_release", resp_a[1].req_ready, 1);
      @(posedge clk); #1;
      set_req(1, 1'b0, CMO_CLEAN);
      drive(1'b0, 1'b1, 8'hF3);
      @(negedge clk);
      chk("fence_ack1c", resp_a[1].ack, 1);
`else
      chk("all_issue_dcreq", dc_req.req, 1);
      chk("all_issue_rdy0", resp_a[0].req_ready, 1);
      @(posedge clk); #1;
      set_req(0, 1'b0, CMO_CLEAN);
      drive(1'b0, 1'b1, 8'hF0);
      @(negedge clk);
      chk("all_ack1a", resp_a[1].trans_id, 8'hF0);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 8'hF1);
      @(negedge clk);
      chk("all_ack1b", resp_a[1].trans_id, 8'hF1);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 8'hF2);
      @(negedge clk);
      chk("all_ack0", resp_a[0].trans_id, 8'hF2);
`endif
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("final_busy", busy, 0);
      chk("final_err", err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
